// File: rtl/call_stack_ctrl.sv
// Return-address stack: circular buffer with level counter, sticky overflow/underflow flags.
// Zero-latency top read; state updates on the edge; no backpressure (full pushes drop or overwrite).
module call_stack_ctrl #(
  parameter int ADDR_W    = 18,
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b0,
  parameter int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] top_addr,
  output logic [LVL_W-1:0]  level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  wp_nxt;
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  level_nxt;
  logic              wr_en;
  logic              set_ovf;
  logic              set_udf;

  assign empty    = (level == '0);
  assign full     = (level == LVL_MAX);
  assign top_ptr  = wp - PTR_W'(1);
  assign top_addr = empty ? '0 : mem[top_ptr];

  // Pointer arithmetic wraps modulo DEPTH, so a stack drained with wp != 0 needs no special case.
  always_comb begin
    wr_en     = 1'b0;
    wr_ptr    = wp;
    wp_nxt    = wp;
    level_nxt = level;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wr_en     = 1'b1;
          wp_nxt    = wp + PTR_W'(1);
          level_nxt = level + LVL_W'(1);
        end else begin
          set_ovf = 1'b1;
          if (OVERWRITE) begin
            wr_en  = 1'b1;
            wp_nxt = wp + PTR_W'(1);
          end
        end
      end
      2'b01: begin
        if (!empty) begin
          wp_nxt    = top_ptr;
          level_nxt = level - LVL_W'(1);
        end else begin
          set_udf = 1'b1;
        end
      end
      2'b11: begin
        if (!empty) begin
          // Replace-top: a RET immediately followed by a CALL in one cycle.
          wr_en  = 1'b1;
          wr_ptr = top_ptr;
        end else begin
          set_udf   = 1'b1;
          wr_en     = 1'b1;
          wp_nxt    = wp + PTR_W'(1);
          level_nxt = level + LVL_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp        <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp        <= wp_nxt;
      level     <= level_nxt;
      overflow  <= set_ovf | (overflow & ~clr_err);
      underflow <= set_udf | (underflow & ~clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr] <= push_addr;
    end
  end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl: DEPTH=4 drop-mode and overwrite-mode instances share stimulus.
module tb_call_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, push, pop, clr_err;
  logic [17:0] push_addr;
  logic [17:0] top0, top1;
  logic [2:0]  lvl0, lvl1;
  logic        emp0, emp1, ful0, ful1, ovf0, ovf1, udf0, udf1;

  always #5 clk = ~clk;

  call_stack_ctrl #(.ADDR_W(18), .DEPTH(4), .OVERWRITE(1'b0)) u_drop (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_addr(push_addr),
    .clr_err(clr_err), .top_addr(top0), .level(lvl0), .empty(emp0), .full(ful0),
    .overflow(ovf0), .underflow(udf0));

  call_stack_ctrl #(.ADDR_W(18), .DEPTH(4), .OVERWRITE(1'b1)) u_ovw (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_addr(push_addr),
    .clr_err(clr_err), .top_addr(top1), .level(lvl1), .empty(emp1), .full(ful1),
    .overflow(ovf1), .underflow(udf1));

  int n_pass = 0;
  int n_chk  = 0;

  // Reference: index 0 = drop mode, 1 = overwrite mode; ms[d][0] is the oldest entry.
  logic [17:0] ms [2][4];
  int          msz [2];
  logic        mov [2];
  logic        mud [2];
  logic [17:0] ret_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [17:0] mtop(input int d);
    return (msz[d] > 0) ? ms[d][msz[d]-1] : 18'h0;
  endfunction

  function automatic logic [17:0] dtop(input int d);
    return (d == 0) ? top0 : top1;
  endfunction

  task automatic model_step(input int d, input logic r, input logic p, input logic q,
                            input logic [17:0] a, input logic c);
    logic sov, sud;
    sov = 1'b0;
    sud = 1'b0;
    if (!r) begin
      msz[d] = 0;
      mov[d] = 1'b0;
      mud[d] = 1'b0;
    end else begin
      if (p && q) begin
        if (msz[d] > 0) ms[d][msz[d]-1] = a;
        else begin
          sud = 1'b1;
          ms[d][0] = a;
          msz[d] = 1;
        end
      end else if (p) begin
        if (msz[d] < 4) begin
          ms[d][msz[d]] = a;
          msz[d]++;
        end else begin
          sov = 1'b1;
          if (d == 1) begin
            for (int i = 0; i < 3; i++) ms[d][i] = ms[d][i+1];
            ms[d][3] = a;
          end
        end
      end else if (q) begin
        if (msz[d] > 0) msz[d]--;
        else sud = 1'b1;
      end
      mov[d] = sov | (mov[d] & ~c);
      mud[d] = sud | (mud[d] & ~c);
    end
  endtask

  task automatic check_state(input int d);
    string s;
    s = (d == 0) ? "drop" : "ovw";
    chk({s, "_level"}, 32'(d == 0 ? lvl0 : lvl1), 32'(msz[d]));
    chk({s, "_empty"}, 32'(d == 0 ? emp0 : emp1), 32'(msz[d] == 0));
    chk({s, "_full"},  32'(d == 0 ? ful0 : ful1), 32'(msz[d] == 4));
    chk({s, "_top"},   32'(dtop(d)), 32'(mtop(d)));
    chk({s, "_ovf"},   32'(d == 0 ? ovf0 : ovf1), 32'(mov[d]));
    chk({s, "_udf"},   32'(d == 0 ? udf0 : udf1), 32'(mud[d]));
  endtask

  // One clock: drive at negedge, check pop return value in-cycle, check state after the edge.
  task automatic cyc(input logic r, input logic p, input logic q,
                     input logic [17:0] a, input logic c);
    rst_n = r; push = p; pop = q; push_addr = a; clr_err = c;
    #1;
    if (r && q) begin
      for (int d = 0; d < 2; d++) begin
        if (ret_q.size() == 0) chk("ret_q_empty", 32'(ret_q.size()), 32'd1);
        else chk((d == 0) ? "drop_ret" : "ovw_ret", 32'(dtop(d)), 32'(ret_q.pop_front()));
      end
    end
    for (int d = 0; d < 2; d++) model_step(d, r, p, q, a, c);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_state(d);
  endtask

  task automatic do_push(input logic [17:0] a);
    cyc(1'b1, 1'b1, 1'b0, a, 1'b0);
  endtask

  task automatic do_pop(input logic [17:0] e0, input logic [17:0] e1);
    ret_q.push_back(e0);
    ret_q.push_back(e1);
    cyc(1'b1, 1'b0, 1'b1, 18'h0, 1'b0);
  endtask

  task automatic do_pp(input logic [17:0] a, input logic c);
    ret_q.push_back(mtop(0));
    ret_q.push_back(mtop(1));
    cyc(1'b1, 1'b1, 1'b1, a, c);
  endtask

  initial begin
    msz[0] = 0; msz[1] = 0;
    mov[0] = 1'b0; mov[1] = 1'b0; mud[0] = 1'b0; mud[1] = 1'b0;

    // Reset held two cycles with push asserted
    cyc(1'b0, 1'b1, 1'b0, 18'h3ffff, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 18'h3ffff, 1'b0);
    chk("rst_level", 32'(lvl0), 32'd0);
    chk("rst_empty", 32'(emp0), 32'd1);
    chk("rst_top",   32'(top0), 32'h0);
    chk("rst_flags", 32'({ovf0, udf0, ovf1, udf1}), 32'd0);

    // LIFO order
    do_push(18'h00010); do_push(18'h00020); do_push(18'h00030);
    chk("lifo_top",   32'(top0), 32'h30);
    chk("lifo_level", 32'(lvl0), 32'd3);
    do_pop(18'h30, 18'h30); do_pop(18'h20, 18'h20); do_pop(18'h10, 18'h10);
    chk("lifo_drained_top", 32'(top0), 32'h0);
    chk("lifo_drained_empty", 32'(emp0), 32'd1);

    // Fill past full: drop keeps 1..4, overwrite keeps 2..5
    for (int i = 1; i <= 5; i++) do_push(18'(i));
    chk("drop_full", 32'(ful0), 32'd1);
    chk("drop_ovf",  32'(ovf0), 32'd1);
    chk("drop_top",  32'(top0), 32'h4);
    chk("ovw_ovf",   32'(ovf1), 32'd1);
    chk("ovw_level", 32'(lvl1), 32'd4);
    chk("ovw_top",   32'(top1), 32'h5);
    do_pop(18'h4, 18'h5); do_pop(18'h3, 18'h4); do_pop(18'h2, 18'h3); do_pop(18'h1, 18'h2);
    do_pop(18'h0, 18'h0);
    chk("pop_empty_udf",   32'(udf1), 32'd1);
    chk("pop_empty_level", 32'(lvl1), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
    chk("clr_flags", 32'({ovf0, udf0, ovf1, udf1}), 32'd0);

    // Simultaneous push and pop
    do_push(18'h05555); do_push(18'h0ABCD);
    do_pp(18'h01234, 1'b0);
    chk("pp_level", 32'(lvl0), 32'd2);
    chk("pp_top",   32'(top0), 32'h1234);
    chk("pp_flags", 32'({ovf0, udf0}), 32'd0);
    do_pop(18'h1234, 18'h1234); do_pop(18'h5555, 18'h5555);
    do_pp(18'h00077, 1'b0);
    chk("pp_empty_level", 32'(lvl0), 32'd1);
    chk("pp_empty_top",   32'(top0), 32'h77);
    chk("pp_empty_udf",   32'(udf0), 32'd1);
    do_pop(18'h77, 18'h77);

    // Set beats clear; clear alone leaves level alone
    ret_q.push_back(18'h0); ret_q.push_back(18'h0);
    cyc(1'b1, 1'b0, 1'b1, 18'h0, 1'b1);
    chk("clr_set_wins", 32'(udf0), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
    chk("clr_alone", 32'({ovf0, udf0}), 32'd0);
    chk("clr_level", 32'(lvl0), 32'd0);

    // Full-stack corner cases and a mid-operation reset
    for (int i = 0; i < 5; i++) do_push(18'h00100 + 18'(i));
    cyc(1'b1, 1'b1, 1'b0, 18'h00105, 1'b1);
    chk("clr_ovf_set_wins", 32'(ovf0), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 18'h0, 1'b1);
    chk("clr_full_level", 32'(lvl0), 32'd4);
    do_pp(18'h001AA, 1'b0);
    chk("pp_full_noflag", 32'({ovf0, udf0, ovf1, udf1}), 32'd0);
    chk("pp_full_top", 32'(top0), 32'h1AA);
    cyc(1'b0, 1'b1, 1'b1, 18'h00222, 1'b1);
    chk("mid_rst_empty", 32'(emp1), 32'd1);

    // Random traffic against the reference
    for (int n = 0; n < 400; n++) begin
      logic r, p, q, c;
      r = ($urandom_range(0, 59) != 0);
      p = $urandom_range(0, 1) == 1;
      q = $urandom_range(0, 1) == 1;
      c = ($urandom_range(0, 7) == 0);
      if (r && q) begin
        ret_q.push_back(mtop(0));
        ret_q.push_back(mtop(1));
      end
      cyc(r, p, q, 18'($urandom), c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
